// File: rtl/clint_pkg.sv
// Shared register offsets, defaults, state/record types and byte-merge helper for the CLINT.
package clint_pkg;

  localparam logic [15:0] clint_msip_addr        = 16'h0000;
  localparam logic [15:0] clint_mtimecmp_lo_addr = 16'h4000;
  localparam logic [15:0] clint_mtimecmp_hi_addr = 16'h4004;
  localparam logic [15:0] clint_mtime_lo_addr    = 16'hBFF8;
  localparam logic [15:0] clint_mtime_hi_addr    = 16'hBFFC;

  localparam int          clint_default_prescale = 1;
  localparam logic [63:0] clint_default_mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic {IDLE, RESP} clint_state_type;

  typedef struct packed {
    clint_state_type state;
    logic [15:0]     addr;
    logic [3:0]      wstrb;
    logic            instr;
    logic            msip;
    logic [63:0]     mtimecmp;
    logic            ready;
    logic [31:0]     rdata;
  } clint_reg_type;

  function automatic logic [31:0] clint_merge(input logic [31:0] old_value,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] result;
    result = old_value;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) result[8*i +: 8] = wdata[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/clint_timer.sv
// Prescaled 64-bit mtime counter with byte-strobed writes and the registered mtip compare.
module clint_timer
  import clint_pkg::*;
#(
  parameter int clint_prescale = clint_default_prescale
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        write_lo,
  input  logic        write_hi,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic [63:0] mtimecmp_next,
  output logic [63:0] mtime,
  output logic        mtip
);

  localparam int count_width = (clint_prescale > 1) ? $clog2(clint_prescale) : 1;
  localparam logic [count_width-1:0] count_last = count_width'(clint_prescale - 1);

  logic [count_width-1:0] count_reg;
  logic [63:0]            mtime_reg;
  logic [63:0]            mtime_next;
  logic                   mtip_reg;
  logic                   tick;

  assign tick = (count_reg == count_last);

  // Any mtime write freezes the whole 64-bit value for that cycle; the prescaler is unaffected.
  always_comb begin
    mtime_next = mtime_reg;
    if (write_lo || write_hi) begin
      if (write_lo) mtime_next[31:0]  = clint_merge(mtime_reg[31:0], wdata, wstrb);
      if (write_hi) mtime_next[63:32] = clint_merge(mtime_reg[63:32], wdata, wstrb);
    end else if (tick) begin
      mtime_next = mtime_reg + 64'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
      mtime_reg <= '0;
      mtip_reg  <= 1'b0;
    end else begin
      count_reg <= tick ? '0 : count_reg + count_width'(1);
      mtime_reg <= mtime_next;
      mtip_reg  <= (mtime_next >= mtimecmp_next);
    end
  end

  assign mtime = mtime_reg;
  assign mtip  = mtip_reg;

endmodule

// File: rtl/clint.sv
// CLINT slave: address decode, two-state handshake, msip/mtimecmp registers.
// Define CLINT_MTIME_LATCH_EN to make 0xBFFC return mtime[63:32] captured by the last 0xBFF8 read.
module clint
  import clint_pkg::*;
#(
  parameter int          clint_prescale       = clint_default_prescale,
  parameter logic [63:0] clint_mtimecmp_reset = clint_default_mtimecmp
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        memory_valid,
  input  logic        memory_instr,
  input  logic [31:0] memory_addr,
  input  logic [31:0] memory_wdata,
  input  logic [3:0]  memory_wstrb,
  output logic [31:0] memory_rdata,
  output logic        memory_ready,
  output logic        msip,
  output logic        mtip,
  output logic [63:0] mtime
);

  localparam clint_reg_type reset_reg = '{
    state:    IDLE,
    addr:     16'h0,
    wstrb:    4'h0,
    instr:    1'b0,
    msip:     1'b0,
    mtimecmp: clint_mtimecmp_reset,
    ready:    1'b0,
    rdata:    32'h0
  };

  clint_reg_type r;
  logic [15:0]   offset;
  logic          accept;
  logic          write_en;
  logic          read_en;
  logic          msip_next;
  logic [63:0]   mtimecmp_next;
  logic [31:0]   read_data;
  logic          unused_bits;

  assign offset   = memory_addr[15:0];
  assign accept   = (r.state == IDLE) && memory_valid;
  assign write_en = accept && !memory_instr && (memory_wstrb != 4'h0);
  assign read_en  = accept && !memory_instr && (memory_wstrb == 4'h0);

  always_comb begin
    msip_next     = r.msip;
    mtimecmp_next = r.mtimecmp;
    if (write_en) begin
      case (offset)
        clint_msip_addr:        if (memory_wstrb[0]) msip_next = memory_wdata[0];
        clint_mtimecmp_lo_addr: mtimecmp_next[31:0]  = clint_merge(r.mtimecmp[31:0], memory_wdata, memory_wstrb);
        clint_mtimecmp_hi_addr: mtimecmp_next[63:32] = clint_merge(r.mtimecmp[63:32], memory_wdata, memory_wstrb);
        default: ;
      endcase
    end
  end

`ifdef CLINT_MTIME_LATCH_EN
  logic [31:0] shadow_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_reg <= 32'h0;
    end else if (read_en && offset == clint_mtime_lo_addr) begin
      shadow_reg <= mtime[63:32];
    end
  end
`else
  logic unused_read_en;
  assign unused_read_en = read_en;
`endif

  always_comb begin
    read_data = 32'h0;
    case (offset)
      clint_msip_addr:        read_data = {31'h0, r.msip};
      clint_mtimecmp_lo_addr: read_data = r.mtimecmp[31:0];
      clint_mtimecmp_hi_addr: read_data = r.mtimecmp[63:32];
      clint_mtime_lo_addr:    read_data = mtime[31:0];
`ifdef CLINT_MTIME_LATCH_EN
      clint_mtime_hi_addr:    read_data = shadow_reg;
`else
      clint_mtime_hi_addr:    read_data = mtime[63:32];
`endif
      default: ;
    endcase
  end

  // Read data is captured at acceptance, so a write returns the value it overwrote.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r <= reset_reg;
    end else begin
      r.msip     <= msip_next;
      r.mtimecmp <= mtimecmp_next;
      case (r.state)
        IDLE: begin
          r.ready <= 1'b0;
          r.rdata <= 32'h0;
          if (memory_valid) begin
            r.state <= RESP;
            r.addr  <= offset;
            r.wstrb <= memory_wstrb;
            r.instr <= memory_instr;
            r.ready <= 1'b1;
            r.rdata <= memory_instr ? 32'h0 : read_data;
          end
        end
        RESP: begin
          r.state <= IDLE;
          r.ready <= 1'b0;
          r.rdata <= 32'h0;
        end
      endcase
    end
  end

  clint_timer #(
    .clint_prescale(clint_prescale)
  ) timer (
    .clock         (clock),
    .reset         (reset),
    .write_lo      (write_en && offset == clint_mtime_lo_addr),
    .write_hi      (write_en && offset == clint_mtime_hi_addr),
    .wdata         (memory_wdata),
    .wstrb         (memory_wstrb),
    .mtimecmp_next (mtimecmp_next),
    .mtime         (mtime),
    .mtip          (mtip)
  );

  // Latched request fields are kept for debug visibility only.
  assign unused_bits = ^{memory_addr[31:16], r.addr, r.wstrb, r.instr};

  assign memory_ready = r.ready;
  assign memory_rdata = r.rdata;
  assign msip         = r.msip;

endmodule
